// File: rtl/fetch_byte_queue_if.sv
// Bundle of ICache request/response and decoder window signals around the fetch byte queue.
// The queue drives the master modport; the ICache/decoder environment uses slave.
interface fetch_byte_queue_if #(
   parameter int LINE_BYTES   = 64,
   parameter int DEPTH_BYTES  = 128,
   parameter int WINDOW_BYTES = 15,
   parameter int ADDR_W       = 64
);
   localparam int CONS_W = $clog2(WINDOW_BYTES + 1);
   localparam int CNT_W  = $clog2(DEPTH_BYTES) + 1;

   logic                      irequest;
   logic [ADDR_W-1:0]         iaddr;
   logic                      idone;
   logic [LINE_BYTES*8-1:0]   idata;
   logic                      redirect;
   logic [ADDR_W-1:0]         redirect_rip;
   logic                      can_decode;
   logic [WINDOW_BYTES*8-1:0] decode_bytes;
   logic [ADDR_W-1:0]         decode_rip;
   logic [CONS_W-1:0]         consume;
   logic [CNT_W-1:0]          fill_count;

   modport master (
      output irequest, iaddr, can_decode, decode_bytes, decode_rip, fill_count,
      input  idone, idata, redirect, redirect_rip, consume
   );

   modport slave (
      input  irequest, iaddr, can_decode, decode_bytes, decode_rip, fill_count,
      output idone, idata, redirect, redirect_rip, consume
   );
endinterface

// File: rtl/fetch_byte_queue.sv
// Instruction-byte queue: fetches aligned ICache lines into a circular byte buffer and
// presents a fixed decode window with its RIP; supports redirect with in-flight line discard.
module fetch_byte_queue #(
   parameter int LINE_BYTES   = 64,
   parameter int DEPTH_BYTES  = 128,
   parameter int WINDOW_BYTES = 15,
   parameter int ADDR_W       = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] entry,
   fetch_byte_queue_if.master bus
);
   localparam int PTR_W  = $clog2(DEPTH_BYTES);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CONS_W = $clog2(WINDOW_BYTES + 1);
   localparam int SKIP_W = $clog2(LINE_BYTES);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t            state, state_next;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [SKIP_W-1:0] skip;
   logic [ADDR_W-1:0] fetch_rip;
   logic [ADDR_W-1:0] iaddr_q;
   logic [ADDR_W-1:0] decode_rip_q;
   logic [7:0]        buffer [DEPTH_BYTES];

   logic              can_decode_int;
   logic              fill_en;
   logic              consume_en;
   logic              issue_en;
   logic [CNT_W-1:0]  fill_amt;
   logic [CNT_W-1:0]  cons_amt;

   // Control decode shared by the FSM and the datapath; redirect masks fill and consume.
   always_comb begin
      can_decode_int = count >= CNT_W'(WINDOW_BYTES);
      fill_en        = (state == WAIT) && bus.idone && !bus.redirect;
      fill_amt       = fill_en ? (CNT_W'(LINE_BYTES) - CNT_W'(skip)) : '0;
      consume_en     = !bus.redirect && can_decode_int && (bus.consume != '0)
                       && (bus.consume <= CONS_W'(WINDOW_BYTES));
      cons_amt       = consume_en ? CNT_W'(bus.consume) : '0;
      issue_en       = (state == IDLE) && !bus.redirect
                       && (count <= CNT_W'(DEPTH_BYTES - LINE_BYTES));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue_en) state_next = WAIT;
         WAIT: begin
            if (bus.idone)         state_next = IDLE;
            else if (bus.redirect) state_next = DISCARD;
         end
         DISCARD: if (bus.idone) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The request is held for the whole WAIT/DISCARD lifetime so the ICache sees a stable level.
   always_comb begin
      bus.irequest   = (state == WAIT) || (state == DISCARD);
      bus.iaddr      = iaddr_q;
      bus.can_decode = can_decode_int;
      bus.fill_count = count;
      bus.decode_rip = decode_rip_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         iaddr_q      <= '0;
         fetch_rip    <= entry & ~LINE_MASK;
         skip         <= entry[SKIP_W-1:0];
         decode_rip_q <= entry;
      end else if (bus.redirect) begin
         wr_ptr       <= rd_ptr;
         count        <= '0;
         fetch_rip    <= bus.redirect_rip & ~LINE_MASK;
         skip         <= bus.redirect_rip[SKIP_W-1:0];
         decode_rip_q <= bus.redirect_rip;
      end else begin
         if (issue_en) iaddr_q <= fetch_rip;
         if (fill_en) begin
            wr_ptr    <= wr_ptr + PTR_W'(fill_amt);
            skip      <= '0;
            fetch_rip <= fetch_rip + ADDR_W'(LINE_BYTES);
         end
         if (consume_en) begin
            rd_ptr       <= rd_ptr + PTR_W'(cons_amt);
            decode_rip_q <= decode_rip_q + ADDR_W'(cons_amt);
         end
         count <= count + fill_amt - cons_amt;
      end
   end

   // Leading bytes below skip are dropped; the rest pack contiguously from wr_ptr with wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH_BYTES; i++) buffer[i] <= '0;
      end else if (fill_en) begin
         for (int k = 0; k < LINE_BYTES; k++) begin
            if (k >= int'(skip))
               buffer[wr_ptr + PTR_W'(k) - PTR_W'(skip)] <= bus.idata[8*k +: 8];
         end
      end
   end

   always_comb begin
      bus.decode_bytes = '0;
      for (int k = 0; k < WINDOW_BYTES; k++)
         bus.decode_bytes[8*k +: 8] = buffer[rd_ptr + PTR_W'(k)];
   end

   a_consume_legal: assert property (@(posedge clk) disable iff (!reset_n)
      ((bus.consume != '0) && !bus.redirect) |-> ((bus.consume <= CONS_W'(WINDOW_BYTES)) && can_decode_int));

endmodule
